tpm_locality_arbiter: RTL
=========================

# tpm_locality_arbiter

Arbitrates ownership of the TPM interface among localities 0–4 per the TPM_ACCESS protocol: requestUse, relinquish, Seize, beenSeized, and pendingRequest. It sits beside the FIFO register block. That block decodes byte writes to TPM_ACCESS_x and forwards them here as single-cycle strobes. It reads back the composed TPM_ACCESS byte and uses `active_valid`/`active_loc` to gate locality-restricted registers (TPM_INT_VECTOR, TPM_STS, FIFO). `loc_change` drives the localityChangeInt source.

## Interface
- `NUM_LOC`, default 5: number of localities; only 5 is supported.
- `clk_i`  in  1: host clock; all state changes on rising edge.
- `rst_i`  in  1: synchronous reset, active-high.
- `acc_wr`  in  1: one-cycle strobe; a byte is written to TPM_ACCESS of locality `acc_loc`.
- `acc_loc`  in  3: locality of the write; values 5–7 are ignored.
- `acc_data`  in  8: written byte.
- `rd_loc`  in  3: locality whose TPM_ACCESS byte is presented on `access_rd`.
- `established`  in  1: tpmEstablishment source, returned in bit 0.
- `access_rd`  out  8: combinational TPM_ACCESS byte for `rd_loc`; 8'hFF for `rd_loc` ≥ 5.
- `active_valid`  out  1: a locality is active.
- `active_loc`  out  3: the active locality; 0 when `active_valid`=0.
- `req_pending`  out  5: per-locality requestUse flags.
- `been_seized`  out  5: per-locality beenSeized flags.
- `loc_change`  out  1: one-cycle pulse when a new locality becomes active.

## Operation
- State machine states:
  - IDLE: no locality is active and no request is pending.
  - ARB: no locality is active and at least one request is pending.
  - ACTIVE: a locality is active.
- Write decode uses `acc_data` bit 1 = requestUse, bit 3 = Seize, bit 4 = clear beenSeized, bit 5 = activeLocality (relinquish).
  - A write with more than one of bits {1,3,4,5} set is ignored entirely.
  - Other bits are don't-care.
- requestUse from L:
  - If L is active: no effect.
  - Otherwise: set `req_pending[L]`; IDLE goes to ARB.
  - Setting an already-set flag is a no-op.
- Relinquish from L:
  - If L is active: the active locality is cleared and `req_pending[L]` is cleared. Next state is ARB if any request remains, else IDLE.
  - If L is not active: only `req_pending[L]` is cleared.
- Seize from L:
  - Honoured only in ACTIVE when L > `active_loc`.
  - Effect: `been_seized[active_loc]` is set, L becomes active, `req_pending[L]` is cleared, and `loc_change` pulses.
  - Otherwise the write is ignored; Seize never creates a request.
- Clear-beenSeized from L: clears `been_seized[L]`.
- ARB: grants the highest-numbered pending locality, clears its `req_pending` bit, enters ACTIVE, and pulses `loc_change`.
- `access_rd` bit layout:
  - bit 7 = 1 (tpmRegValidSts).
  - bit 6 = 0.
  - bit 5 = (active_valid && active_loc == rd_loc).
  - bit 4 = `been_seized[rd_loc]`.
  - bit 3 = 0 (Seize reads as 0).
  - bit 2 = pendingRequest, i.e. any `req_pending` bit other than `rd_loc` is set.
  - bit 1 = `req_pending[rd_loc]`.
  - bit 0 = `established`.

## Timing
- Reset values: state IDLE; `active_valid`=0, `active_loc`=0, `req_pending`=0, `been_seized`=0, `loc_change`=0.
  - `access_rd` then reads 8'h80 | `established`.
- All outputs except `access_rd` are registered.
- Only one write per cycle exists, so no two writes are ever simultaneous.
- requestUse sampled at edge N with nothing active:
  - `req_pending` set after edge N.
  - Grant at edge N+1: `active_valid`=1 and `loc_change`=1 in cycle N+1 only.
- Relinquish by the active locality at edge N: `active_valid`=0 after N. If requests remain, the next grant occurs at edge N+1.
- Seize at edge N: new owner and `been_seized` are visible after edge N, with no idle gap; `loc_change` is high for that one cycle.
- A write arriving in the same cycle as the ARB grant edge is evaluated against the pre-grant state. Its result combines with the grant as follows:
  - A request from another locality stays pending.
  - A relinquish from the winner clears its request before the grant, and the grant goes to the next pending locality (or IDLE).
  - A Seize is ignored, because the state is not yet ACTIVE.
- Reset asserted mid-operation overrides any concurrent `acc_wr` and returns all state to reset values at that edge.

## Structure
- The shared defines header gains:
  - TPM_ACCESS bit-position constants (`ACC_EST`, `ACC_REQ_USE`, `ACC_PENDING`, `ACC_SEIZE`, `ACC_BEEN_SEIZED`, `ACC_ACTIVE`, `ACC_VALID`).
  - the state encodings.
  - a `NUM_LOC` constant.
- One sub-module, `tpm_loc_prio_enc`: 5-bit highest-set-bit priority encoder producing a 3-bit index plus a valid flag, used by ARB.

## Test plan
- Reset:
  - Stimulus: reset; then read all five `access_rd` values with `established`=1.
  - Required: each reads 8'h81; `active_valid`=0.
- requestUse from an idle state:
  - Stimulus: write 8'h02 to locality 0.
  - Required: cycle N+1 shows `active_loc`=0, `active_valid`=1, and `loc_change` pulses once; `access_rd`(0) = 8'hA0 with `established`=0.
- Queued handover on relinquish:
  - Stimulus: with locality 0 active, requestUse from 2 and 3; then write 8'h20 from locality 0.
  - Required: before the relinquish, `access_rd`(0) bit 2 = 1. After it, locality 3 is granted one cycle later, then locality 2 after 3 relinquishes.
- Seize:
  - Stimulus: locality 1 active; locality 4 writes 8'h08.
  - Required: `active_loc`=4 on the next cycle, `been_seized`=5'b00010, `access_rd`(1) bit 4 = 1.
  - Stimulus: locality 1 writes 8'h10.
  - Required: `been_seized` clears.
- Ignored writes:
  - Stimulus: Seize from 0 while 2 is active, or from anyone while idle; write 8'h22; write to `acc_loc`=6.
  - Required: none of these change state.
- Reset mid-operation:
  - Stimulus: assert `rst_i` in the same cycle as a Seize strobe.
  - Required: all outputs return to reset values; no `loc_change` pulse.

Source files
------------

// File: rtl/tpm_locality_arbiter_pkg.sv
// Purpose: shared constants and types for the TPM locality arbiter slice.
// Latency: n/a (constants, types and state encodings only).
// Backpressure: n/a.
package tpm_locality_arbiter_pkg;

  // Number of TPM localities (0..4).
  localparam int NUM_LOC = 5;

  // TPM_ACCESS bit positions, shared by the write decode and the read-back.
  localparam int ACC_EST         = 0;  // tpmEstablishment
  localparam int ACC_REQ_USE     = 1;  // requestUse
  localparam int ACC_PENDING     = 2;  // pendingRequest (read only)
  localparam int ACC_SEIZE       = 3;  // Seize (write only, reads 0)
  localparam int ACC_BEEN_SEIZED = 4;  // beenSeized
  localparam int ACC_ACTIVE      = 5;  // activeLocality
  localparam int ACC_VALID       = 7;  // tpmRegValidSts

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // nobody active, nothing pending
    ST_ARB    = 2'd1,  // nobody active, requests pending
    ST_ACTIVE = 2'd2   // one locality owns the interface
  } arb_state_t;

endpackage

// File: rtl/tpm_loc_prio_enc.sv
// Purpose: 5-bit highest-set-bit priority encoder used to pick the ARB winner.
// Latency: combinational.
// Backpressure: none.
// Ports: i_req = request vector; o_idx = index of highest set bit; o_vld = any bit set.
module tpm_loc_prio_enc (
  input  logic [4:0] i_req,
  output logic [2:0] o_idx,
  output logic       o_vld
);

  always_comb begin
    o_idx = 3'd0;
    o_vld = |i_req;
    // Ascending scan: the last hit is the highest-numbered request.
    for (int i = 0; i < 5; i++) begin
      if (i_req[i]) begin
        o_idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/tpm_locality_arbiter.sv
// Purpose: arbitrates TPM interface ownership among localities 0-4 (requestUse/relinquish/Seize).
// Latency: a write takes effect at the next edge; a grant follows one cycle after the request/relinquish.
// Backpressure: none; every strobe is consumed in the cycle it is presented.
// Ports: clk_i/rst_i clock and sync reset; acc_wr/acc_loc/acc_data TPM_ACCESS write strobe;
//        rd_loc/established/access_rd read-back; active_valid/active_loc owner;
//        req_pending/been_seized per-locality flags; loc_change new-owner pulse.
module tpm_locality_arbiter #(
  parameter int NUM_LOC = tpm_locality_arbiter_pkg::NUM_LOC
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               acc_wr,
  input  logic [2:0]         acc_loc,
  input  logic [7:0]         acc_data,
  input  logic [2:0]         rd_loc,
  input  logic               established,
  output logic [7:0]         access_rd,
  output logic               active_valid,
  output logic [2:0]         active_loc,
  output logic [NUM_LOC-1:0] req_pending,
  output logic [NUM_LOC-1:0] been_seized,
  output logic               loc_change
);

  import tpm_locality_arbiter_pkg::*;

  arb_state_t         r_state;
  logic               r_active_valid;
  logic [2:0]         r_active_loc;
  logic [NUM_LOC-1:0] r_pend;
  logic [NUM_LOC-1:0] r_been_seized;
  logic               r_loc_change;

  logic               w_op_ok;
  logic [NUM_LOC-1:0] w_loc_mask;
  logic [NUM_LOC-1:0] w_act_mask;
  logic [NUM_LOC-1:0] w_req_mask;
  logic [NUM_LOC-1:0] w_rel_mask;
  logic [NUM_LOC-1:0] w_clr_mask;
  logic [NUM_LOC-1:0] w_pend_wr;
  logic [NUM_LOC-1:0] w_arb_req;
  logic [NUM_LOC-1:0] w_grant_mask;
  logic [NUM_LOC-1:0] w_rd_mask;
  logic [2:0]         w_grant_idx;
  logic               w_grant_vld;
  logic               w_seize_ok;
  logic               w_rel_owner;
  logic [7:0]         w_access_rd;
  logic               w_unused_data;

  // Bits outside the four command bits carry no meaning on a write.
  assign w_unused_data = ^{acc_data[7:6], acc_data[ACC_PENDING], acc_data[ACC_EST]};

  // A write is acted on only for a real locality and with exactly one command bit set.
  assign w_op_ok = acc_wr && (acc_loc < 3'(NUM_LOC)) &&
                   $onehot({acc_data[ACC_ACTIVE], acc_data[ACC_BEEN_SEIZED],
                            acc_data[ACC_SEIZE], acc_data[ACC_REQ_USE]});

  assign w_loc_mask = NUM_LOC'(1) << acc_loc;
  assign w_act_mask = r_active_valid ? (NUM_LOC'(1) << r_active_loc) : '0;

  // requestUse from the current owner is meaningless and dropped.
  assign w_req_mask = (w_op_ok && acc_data[ACC_REQ_USE])     ? (w_loc_mask & ~w_act_mask) : '0;
  assign w_rel_mask = (w_op_ok && acc_data[ACC_ACTIVE])      ? w_loc_mask : '0;
  assign w_clr_mask = (w_op_ok && acc_data[ACC_BEEN_SEIZED]) ? w_loc_mask : '0;

  assign w_pend_wr = (r_pend | w_req_mask) & ~w_rel_mask;

  // The grant sees the pre-write pending set minus any relinquish: a request
  // landing on the grant edge waits, a relinquish from the winner removes it.
  assign w_arb_req = r_pend & ~w_rel_mask;

  tpm_loc_prio_enc u_prio_enc (
    .i_req (w_arb_req),
    .o_idx (w_grant_idx),
    .o_vld (w_grant_vld)
  );

  assign w_grant_mask = NUM_LOC'(1) << w_grant_idx;

  assign w_seize_ok  = w_op_ok && acc_data[ACC_SEIZE] && (r_state == ST_ACTIVE) &&
                       (acc_loc > r_active_loc);
  assign w_rel_owner = w_op_ok && acc_data[ACC_ACTIVE] && (r_state == ST_ACTIVE) &&
                       (acc_loc == r_active_loc);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= ST_IDLE;
      r_active_valid <= 1'b0;
      r_active_loc   <= 3'd0;
      r_pend         <= '0;
      r_been_seized  <= '0;
      r_loc_change   <= 1'b0;
    end else begin
      r_loc_change  <= 1'b0;
      r_been_seized <= (r_been_seized | (w_seize_ok ? w_act_mask : '0)) & ~w_clr_mask;
      case (r_state)
        ST_IDLE: begin
          r_pend <= w_pend_wr;
          if (|w_pend_wr) begin
            r_state <= ST_ARB;
          end
        end
        ST_ARB: begin
          if (w_grant_vld) begin
            r_pend         <= w_pend_wr & ~w_grant_mask;
            r_state        <= ST_ACTIVE;
            r_active_valid <= 1'b1;
            r_active_loc   <= w_grant_idx;
            r_loc_change   <= 1'b1;
          end else begin
            r_pend  <= w_pend_wr;
            r_state <= (|w_pend_wr) ? ST_ARB : ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (w_rel_owner) begin
            r_pend         <= w_pend_wr;
            r_active_valid <= 1'b0;
            r_active_loc   <= 3'd0;
            r_state        <= (|w_pend_wr) ? ST_ARB : ST_IDLE;
          end else if (w_seize_ok) begin
            // Ownership moves straight to the seizer with no idle gap.
            r_pend       <= w_pend_wr & ~w_loc_mask;
            r_active_loc <= acc_loc;
            r_loc_change <= 1'b1;
          end else begin
            r_pend <= w_pend_wr;
          end
        end
        default: begin
          r_state        <= ST_IDLE;
          r_active_valid <= 1'b0;
          r_active_loc   <= 3'd0;
          r_pend         <= '0;
        end
      endcase
    end
  end

  // Read-back of TPM_ACCESS for rd_loc; unimplemented localities read all ones.
  always_comb begin
    w_rd_mask   = NUM_LOC'(1) << rd_loc;
    w_access_rd = 8'hFF;
    if (rd_loc < 3'(NUM_LOC)) begin
      w_access_rd                  = 8'h00;
      w_access_rd[ACC_VALID]       = 1'b1;
      w_access_rd[ACC_ACTIVE]      = r_active_valid && (r_active_loc == rd_loc);
      w_access_rd[ACC_BEEN_SEIZED] = |(r_been_seized & w_rd_mask);
      w_access_rd[ACC_PENDING]     = |(r_pend & ~w_rd_mask);
      w_access_rd[ACC_REQ_USE]     = |(r_pend & w_rd_mask);
      w_access_rd[ACC_EST]         = established;
    end
  end

  assign access_rd    = w_access_rd;
  assign active_valid = r_active_valid;
  assign active_loc   = r_active_loc;
  assign req_pending  = r_pend;
  assign been_seized  = r_been_seized;
  assign loc_change   = r_loc_change;

endmodule
